// File: rtl/mem_port_arbiter_if.sv
// Bundle of request, response and shared-memory signals for mem_port_arbiter.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface mem_port_arbiter_if;
    logic       flush;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_gnt;
    logic       if_done;
    logic [7:0] if_rdata;
    logic       ls_req;
    logic       ls_we;
    logic [7:0] ls_addr;
    logic [7:0] ls_wdata;
    logic       ls_gnt;
    logic       ls_done;
    logic [7:0] ls_rdata;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       busy;
    logic       bus_err;

    modport master (
        output flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        input  if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, bus_err
    );

    modport slave (
        input  flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        output if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single memory port with
// starvation guard, access timeout and flush cancellation of fetches.
//
// state    | meaning
// IDLE     | no access; arbitrate eligible requests
// ACCESS   | mem_en high, waiting for mem_ready or timeout
// COMPLETE | done (and possibly bus_err) pulse for the winner
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 15
) (
    input logic internal_clock,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

    state_t        state, state_n;
    logic          owner_if, owner_if_n;
    logic          cancel, cancel_n;
    logic [SW-1:0] starve_cnt, starve_cnt_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic          mem_en_q, mem_en_n, mem_we_q, mem_we_n;
    logic [7:0]    mem_addr_q, mem_addr_n, mem_wdata_q, mem_wdata_n;
    logic          if_gnt_q, if_gnt_n, ls_gnt_q, ls_gnt_n;
    logic          if_done_q, if_done_n, ls_done_q, ls_done_n;
    logic [7:0]    if_rdata_q, if_rdata_n, ls_rdata_q, ls_rdata_n;
    logic          busy_q, busy_n, bus_err_q, bus_err_n;
    logic          fetch_ok, pick_if;
    logic [7:0]    rd_val;

    always_ff @(posedge internal_clock) begin
        if (reset) begin
            state       <= IDLE;
            owner_if    <= 1'b0;
            cancel      <= 1'b0;
            starve_cnt  <= '0;
            wait_cnt    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'h00;
            mem_wdata_q <= 8'h00;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_rdata_q  <= 8'h00;
            ls_rdata_q  <= 8'h00;
            busy_q      <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state       <= state_n;
            owner_if    <= owner_if_n;
            cancel      <= cancel_n;
            starve_cnt  <= starve_cnt_n;
            wait_cnt    <= wait_cnt_n;
            mem_en_q    <= mem_en_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            if_gnt_q    <= if_gnt_n;
            ls_gnt_q    <= ls_gnt_n;
            if_done_q   <= if_done_n;
            ls_done_q   <= ls_done_n;
            if_rdata_q  <= if_rdata_n;
            ls_rdata_q  <= ls_rdata_n;
            busy_q      <= busy_n;
            bus_err_q   <= bus_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_if_n   = owner_if;
        cancel_n     = cancel;
        starve_cnt_n = starve_cnt;
        wait_cnt_n   = wait_cnt;
        mem_en_n     = mem_en_q;
        mem_we_n     = mem_we_q;
        mem_addr_n   = mem_addr_q;
        mem_wdata_n  = mem_wdata_q;
        if_gnt_n     = 1'b0;
        ls_gnt_n     = 1'b0;
        if_done_n    = 1'b0;
        ls_done_n    = 1'b0;
        if_rdata_n   = if_rdata_q;
        ls_rdata_n   = ls_rdata_q;
        bus_err_n    = 1'b0;
        fetch_ok     = bus.if_req & ~bus.flush;
        pick_if      = fetch_ok & (~bus.ls_req | (starve_cnt == STARVE_MAX));
        rd_val       = bus.mem_ready ? bus.mem_rdata : 8'h00;

        case (state)
            IDLE: begin
                cancel_n = 1'b0;
                if (fetch_ok || bus.ls_req) begin
                    state_n    = ACCESS;
                    owner_if_n = pick_if;
                    wait_cnt_n = '0;
                    mem_en_n   = 1'b1;
                    if (pick_if) begin
                        mem_addr_n   = bus.if_addr;
                        mem_we_n     = 1'b0;
                        mem_wdata_n  = 8'h00;
                        if_gnt_n     = 1'b1;
                        starve_cnt_n = '0;
                    end else begin
                        mem_addr_n  = bus.ls_addr;
                        mem_we_n    = bus.ls_we;
                        mem_wdata_n = bus.ls_wdata;
                        ls_gnt_n    = 1'b1;
                        if (fetch_ok && starve_cnt != STARVE_MAX)
                            starve_cnt_n = starve_cnt + 1'b1;
                    end
                end
            end
            ACCESS: begin
                cancel_n   = cancel | (owner_if & bus.flush);
                wait_cnt_n = wait_cnt + 1'b1;
                // Timeout finishes like a normal completion but with zero data and bus_err.
                if (bus.mem_ready || wait_cnt == WAIT_LAST) begin
                    state_n   = COMPLETE;
                    mem_en_n  = 1'b0;
                    bus_err_n = ~bus.mem_ready;
                    if (owner_if) begin
                        if (!cancel_n) begin
                            if_done_n  = 1'b1;
                            if_rdata_n = rd_val;
                        end
                    end else begin
                        ls_done_n  = 1'b1;
                        ls_rdata_n = rd_val;
                    end
                end
            end
            COMPLETE: begin
                cancel_n = cancel | (owner_if & bus.flush);
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.ls_gnt    = ls_gnt_q;
    assign bus.if_done   = if_done_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, latency and data.
module tb_mem_port_arbiter;
    localparam int STARVE_LIMIT = 3;
    localparam int TIMEOUT      = 15;

    logic internal_clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_mis = 0;

    // model state
    int         losses = 0;
    logic [7:0] exp_if_rdata = 8'h00;
    logic [7:0] exp_ls_rdata = 8'h00;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .internal_clock (internal_clock),
        .reset          (reset),
        .bus            (bus)
    );

    always #5 internal_clock = ~internal_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge internal_clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush     = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = 8'h00;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_addr   = 8'h00;
        bus.ls_wdata  = 8'h00;
        bus.mem_rdata = 8'h00;
        bus.mem_ready = 1'b0;
    endtask

    // Called 1 time unit after a rising edge while the arbiter is idle.
    // d: ACCESS cycle on which mem_ready rises (0 = never, forcing timeout).
    // fat: ACCESS cycle on which flush is pulsed (0 = none).
    task automatic run_txn(input bit ir, input bit lr, input bit fl_idle, input bit we,
                           input logic [7:0] ia, input logic [7:0] la, input logic [7:0] wd,
                           input int d, input int fat, input logic [7:0] rd);
        bit   if_ok, win_if, cancel, timed_out;
        int   len;
        logic [7:0] val;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.ls_req   = lr;
        bus.ls_we    = we;
        bus.ls_addr  = la;
        bus.ls_wdata = wd;
        bus.flush    = fl_idle;
        bus.mem_ready = 1'b0;
        @(negedge internal_clock);
        chk("idle_busy", bus.busy, 0);
        chk("idle_gnt", {bus.if_gnt, bus.ls_gnt}, 0);
        chk("idle_done", {bus.if_done, bus.ls_done}, 0);

        if_ok = ir && !fl_idle;
        if (!if_ok && !lr) begin
            next_cycle();
            clear_inputs();
            return;
        end
        win_if = if_ok && (!lr || losses == STARVE_LIMIT);
        if (win_if) losses = 0;
        else if (if_ok && losses < STARVE_LIMIT) losses++;

        next_cycle();
        timed_out = (d == 0);
        len = timed_out ? TIMEOUT : d;
        cancel = 0;
        for (int k = 1; k <= len; k++) begin
            bus.mem_ready = (k == d);
            bus.mem_rdata = (k == d) ? rd : 8'($urandom);
            bus.flush     = (k == fat);
            bus.if_req    = 1'($urandom);
            bus.ls_req    = 1'($urandom);
            bus.if_addr   = 8'($urandom);
            bus.ls_addr   = 8'($urandom);
            if (win_if && k == fat) cancel = 1;
            @(negedge internal_clock);
            chk("acc_mem_en", bus.mem_en, 1);
            chk("acc_busy", bus.busy, 1);
            chk("acc_addr", bus.mem_addr, win_if ? ia : la);
            chk("acc_we", bus.mem_we, (!win_if && we) ? 1 : 0);
            if (!win_if) chk("acc_wdata", bus.mem_wdata, wd);
            if (k == 1) chk("acc_gnt", {bus.if_gnt, bus.ls_gnt}, win_if ? 2'b10 : 2'b01);
            else        chk("acc_gnt_off", {bus.if_gnt, bus.ls_gnt}, 0);
            chk("acc_done_off", {bus.if_done, bus.ls_done, bus.bus_err}, 0);
            next_cycle();
        end

        clear_inputs();
        val = timed_out ? 8'h00 : rd;
        if (!win_if) exp_ls_rdata = val;
        else if (!cancel) exp_if_rdata = val;
        @(negedge internal_clock);
        chk("cmp_busy", bus.busy, 1);
        chk("cmp_mem_en", bus.mem_en, 0);
        chk("cmp_if_done", bus.if_done, (win_if && !cancel) ? 1 : 0);
        chk("cmp_ls_done", bus.ls_done, win_if ? 0 : 1);
        chk("cmp_bus_err", bus.bus_err, timed_out ? 1 : 0);
        chk("cmp_if_rdata", bus.if_rdata, exp_if_rdata);
        chk("cmp_ls_rdata", bus.ls_rdata, exp_ls_rdata);
        next_cycle();
    endtask

    task automatic reset_mid_access();
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h44;
        next_cycle();
        bus.if_req = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        losses = 0;
        exp_if_rdata = 8'h00;
        exp_ls_rdata = 8'h00;
        @(negedge internal_clock);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_done", {bus.if_done, bus.ls_done, bus.bus_err}, 0);
        chk("rst_if_rdata", bus.if_rdata, 8'h00);
        next_cycle();
        @(negedge internal_clock);
        chk("rst_after_done", {bus.if_done, bus.ls_done, bus.busy}, 0);
        next_cycle();
    endtask

    initial begin
        int d, len, fat;
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge internal_clock);
        chk("por_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        chk("por_handshake", {bus.if_gnt, bus.ls_gnt, bus.if_done, bus.ls_done}, 0);
        chk("por_rdata", {bus.if_rdata, bus.ls_rdata}, 0);
        chk("por_status", {bus.busy, bus.bus_err}, 0);
        next_cycle();

        // basic fetch, minimum latency
        run_txn(1, 0, 0, 0, 8'h10, 8'h00, 8'h00, 1, 0, 8'hA5);
        // simultaneous requests: load-store write first, then fetch
        run_txn(1, 1, 0, 1, 8'h11, 8'h20, 8'h3C, 1, 0, 8'h5A);
        run_txn(1, 0, 0, 0, 8'h11, 8'h00, 8'h00, 2, 0, 8'h77);
        // starvation guard: fetch wins on the fourth contested arbitration
        for (int i = 0; i < 5; i++)
            run_txn(1, 1, 0, 0, 8'h30, 8'h40 + 8'(i), 8'h00, 1, 0, 8'h90 + 8'(i));
        // flushed fetch completes silently
        run_txn(1, 0, 0, 0, 8'h50, 8'h00, 8'h00, 2, 1, 8'hEE);
        // flush in idle blocks fetch but not load-store
        run_txn(1, 0, 1, 0, 8'h51, 8'h00, 8'h00, 1, 0, 8'h12);
        run_txn(1, 1, 1, 0, 8'h52, 8'h61, 8'h00, 1, 0, 8'h34);
        // timeouts for both requesters, and ready on the last allowed cycle
        run_txn(0, 1, 0, 0, 8'h00, 8'h70, 8'h00, 0, 0, 8'hFF);
        run_txn(1, 0, 0, 0, 8'h71, 8'h00, 8'h00, 0, 0, 8'hFF);
        run_txn(1, 0, 0, 0, 8'h72, 8'h00, 8'h00, TIMEOUT, 0, 8'hC3);
        reset_mid_access();

        for (int t = 0; t < 300; t++) begin
            d   = ($urandom_range(0, 9) == 0) ? 0 :
                  (($urandom_range(0, 7) == 0) ? $urandom_range(1, TIMEOUT) : $urandom_range(1, 4));
            len = (d == 0) ? TIMEOUT : d;
            fat = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
            run_txn(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), d, fat, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
